// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty controller.
package pwm_pkg;

  localparam int PWM_CBITS = 14;
  localparam int DUTY_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus debouncer for the duty switches.
// target follows the switches only after DB_LIMIT+1 cycles of stable input.
module sw_debounce
  import pwm_pkg::*;
#(
  parameter int DB_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_raw,
  output logic [DUTY_W-1:0] target,
  output logic              target_upd
);

  localparam logic [DB_BITS-1:0] DB_LIMIT = '1;

  logic [DUTY_W-1:0]  sync1;
  logic [DUTY_W-1:0]  sw_sync;
  logic [DUTY_W-1:0]  cand;
  logic [DB_BITS-1:0] db_cnt;
  logic               stable;

  assign stable = (db_cnt == DB_LIMIT) && (sw_sync == cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sw_sync    <= '0;
      cand       <= '0;
      db_cnt     <= '0;
      target     <= '0;
      target_upd <= 1'b0;
    end else begin
      sync1   <= sw_raw;
      sw_sync <= sync1;
      if (sw_sync != cand) begin
        cand   <= sw_sync;
        db_cnt <= '0;
      end else if (db_cnt != DB_LIMIT) begin
        db_cnt <= db_cnt + 1'b1;
      end
      // target_upd flags only real changes, visible together with the new target
      target_upd <= 1'b0;
      if (stable) begin
        target     <= cand;
        target_upd <= (cand != target);
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Debounced, period-aligned duty code generator for a downstream PWM.
// Define PWM_DUTY_RAMP_EN to ramp duty one step per RAMP_PERIODS periods; otherwise duty jumps.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int CBITS        = PWM_CBITS,
  parameter int DB_BITS      = 16,
  parameter int RAMP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_raw,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              period_start,
  output logic              busy
);

  logic [DUTY_W-1:0] target;
  logic              target_upd;
  logic [CBITS-1:0]  period_cnt;
  logic [DUTY_W-1:0] duty_next;

  sw_debounce #(
    .DB_BITS (DB_BITS)
  ) u_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .target     (target),
    .target_upd (target_upd)
  );

  assign period_start = &period_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // duty only moves on the edge closing a period_start cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty       <= duty_next;
      duty_valid <= (duty_next != duty);
    end
  end

`ifdef PWM_DUTY_RAMP_EN

  localparam int DIV_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_PERIODS - 1);

  ramp_state_t      state;
  ramp_state_t      state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
    end
  end

  // state tracks the duty value being written this cycle, so busy drops with the last step
  always_comb begin
    duty_next  = duty;
    div_next   = div_cnt;
    state_next = state;
    if (state != IDLE && period_start) begin
      if (div_cnt == DIV_LAST) begin
        div_next = '0;
        if (state == RAMP_UP && duty < target) begin
          duty_next = duty + 1'b1;
        end else if (state == RAMP_DN && duty > target) begin
          duty_next = duty - 1'b1;
        end
      end else begin
        div_next = div_cnt + 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (target_upd || target != duty) begin
          if (target > duty) begin
            state_next = RAMP_UP;
          end else if (target < duty) begin
            state_next = RAMP_DN;
          end
        end
      end
      default: begin
        if (target > duty_next) begin
          state_next = RAMP_UP;
        end else if (target < duty_next) begin
          state_next = RAMP_DN;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
    if (state_next == IDLE) begin
      div_next = '0;
    end
  end

  assign busy = (state != IDLE);

`else

  logic pending;
  logic load;

  // a new target waits for the next period boundary, including one arriving in that same cycle
  assign load = period_start && (pending || target_upd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b0;
    end else if (target_upd) begin
      pending <= 1'b1;
    end
  end

  always_comb begin
    duty_next = duty;
    if (load) begin
      duty_next = target;
    end
  end

  assign busy = 1'b0;

`endif

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with CBITS=4, DB_BITS=3, RAMP_PERIODS=2.
// Expected timings are counted in clk edges after reset release (k).
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_raw = 4'd0;
  logic [3:0] duty;
  logic       duty_valid;
  logic       period_start;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int k = 0;

  pwm_duty_ctrl #(
    .CBITS        (4),
    .DB_BITS      (3),
    .RAMP_PERIODS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset(input logic [3:0] s);
    @(negedge clk);
    rst_n  = 1'b0;
    sw_raw = s;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({duty, duty_valid, period_start, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000", {duty, duty_valid, period_start, busy});
    end
    checks++;
    if (dut.target !== 4'd0) begin
      errors++;
      $display("FAIL reset_target got %0d exp 0", dut.target);
    end
    do_reset(4'd0);
    repeat (2) tick();
    checks++;
    if ({duty, duty_valid, busy} !== 6'd0) begin
      errors++;
      $display("FAIL post_reset got %b exp 000000", {duty, duty_valid, busy});
    end
  endtask

  task automatic test_period_start();
    int pulses;
    logic exp_p;
    pulses = 0;
    do_reset(4'd0);
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_p = ((k % 16) == 15);
      if (period_start === 1'b1) pulses++;
      checks++;
      if (period_start !== exp_p) begin
        errors++;
        $display("FAIL period_start k=%0d got %b exp %b", k, period_start, exp_p);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL period_start_count got %0d exp 4", pulses);
    end
  endtask

  task automatic test_debounce_glitch();
    do_reset(4'd0);
    for (int i = 0; i < 100; i++) begin
      if ((i % 5) == 0) sw_raw[0] = ~sw_raw[0];
      tick();
      checks++;
      if ({dut.target, duty, busy, duty_valid} !== 10'd0) begin
        errors++;
        $display("FAIL glitch k=%0d got target=%0d duty=%0d busy=%b valid=%b exp all 0",
                 k, dut.target, duty, busy, duty_valid);
      end
    end
    sw_raw = 4'd0;
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp_t;
    logic [3:0] exp_d;
    logic       exp_v;
    logic       exp_b;
    int         q;
    int         pulses;
    pulses = 0;
    do_reset(4'd3);
    for (int i = 0; i < 110; i++) begin
      tick();
      exp_t = (k >= 11) ? 4'd3 : 4'd0;
`ifdef PWM_DUTY_RAMP_EN
      q     = (k / 32 > 3) ? 3 : k / 32;
      exp_d = 4'(q);
      exp_v = (k == 32) || (k == 64) || (k == 96);
      exp_b = (k >= 12) && (k < 96);
`else
      q     = 0;
      exp_d = (k >= 16) ? 4'd3 : 4'd0;
      exp_v = (k == 16);
      exp_b = 1'b0;
`endif
      if (duty_valid === 1'b1) pulses++;
      checks++;
      if (dut.target !== exp_t) begin
        errors++;
        $display("FAIL ramp_up_target k=%0d got %0d exp %0d", k, dut.target, exp_t);
      end
      checks++;
      if (duty !== exp_d) begin
        errors++;
        $display("FAIL ramp_up_duty k=%0d got %0d exp %0d", k, duty, exp_d);
      end
      checks++;
      if (duty_valid !== exp_v) begin
        errors++;
        $display("FAIL ramp_up_valid k=%0d got %b exp %b", k, duty_valid, exp_v);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL ramp_up_busy k=%0d got %b exp %b", k, busy, exp_b);
      end
    end
    checks++;
`ifdef PWM_DUTY_RAMP_EN
    if (pulses != 3) begin
      errors++;
      $display("FAIL ramp_up_pulses got %0d exp 3", pulses);
    end
`else
    if (pulses != 1) begin
      errors++;
      $display("FAIL ramp_up_pulses got %0d exp 1", pulses);
    end
`endif
  endtask

`ifdef PWM_DUTY_RAMP_EN
  task automatic test_retarget();
    logic [3:0]  exp_d;
    logic        exp_v;
    logic        exp_b;
    ramp_state_t exp_s;
    int          max_d;
    max_d = 0;
    do_reset(4'hF);
    for (int i = 0; i < 270; i++) begin
      tick();
      if (k < 192)      exp_d = 4'(k / 32);
      else if (k < 224) exp_d = 4'd4;
      else if (k < 256) exp_d = 4'd3;
      else              exp_d = 4'd2;
      exp_v = ((k % 32) == 0) && (k >= 32) && (k <= 256);
      exp_b = (k >= 12) && (k < 256);
      if (k < 12)       exp_s = IDLE;
      else if (k < 172) exp_s = RAMP_UP;
      else if (k < 256) exp_s = RAMP_DN;
      else              exp_s = IDLE;
      if (k >= 160 && int'(duty) > max_d) max_d = int'(duty);
      checks++;
      if (duty !== exp_d) begin
        errors++;
        $display("FAIL retarget_duty k=%0d got %0d exp %0d", k, duty, exp_d);
      end
      checks++;
      if (duty_valid !== exp_v) begin
        errors++;
        $display("FAIL retarget_valid k=%0d got %b exp %b", k, duty_valid, exp_v);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL retarget_busy k=%0d got %b exp %b", k, busy, exp_b);
      end
      checks++;
      if (dut.state !== exp_s) begin
        errors++;
        $display("FAIL retarget_state k=%0d got %0d exp %0d", k, dut.state, exp_s);
      end
      if (k == 170) begin
        checks++;
        if (dut.target !== 4'd15) begin
          errors++;
          $display("FAIL retarget_target_old got %0d exp 15", dut.target);
        end
      end
      if (k == 171) begin
        checks++;
        if (dut.target !== 4'd2) begin
          errors++;
          $display("FAIL retarget_target_new got %0d exp 2", dut.target);
        end
      end
      if (k == 160) sw_raw = 4'd2;
    end
    checks++;
    if (max_d > 5) begin
      errors++;
      $display("FAIL retarget_overshoot got %0d exp <=5", max_d);
    end
  endtask
`else
  task automatic test_step_jump();
    logic [3:0] exp_d;
    logic       exp_v;
    int         pulses;
    pulses = 0;
    do_reset(4'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      exp_d = (k >= 32) ? 4'd9 : 4'd0;
      exp_v = (k == 32);
      if (duty_valid === 1'b1) pulses++;
      checks++;
      if (duty !== exp_d) begin
        errors++;
        $display("FAIL jump_duty k=%0d got %0d exp %0d", k, duty, exp_d);
      end
      checks++;
      if (duty_valid !== exp_v) begin
        errors++;
        $display("FAIL jump_valid k=%0d got %b exp %b", k, duty_valid, exp_v);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL jump_busy k=%0d got %b exp 0", k, busy);
      end
      if (k == 20) sw_raw = 4'd9;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL jump_pulses got %0d exp 1", pulses);
    end
  endtask
`endif

  task automatic test_reset_mid_ramp();
    logic [3:0] exp_d;
    int         run_len;
`ifdef PWM_DUTY_RAMP_EN
    run_len = 224;
`else
    run_len = 20;
`endif
    do_reset(4'hF);
    repeat (run_len) tick();
    checks++;
`ifdef PWM_DUTY_RAMP_EN
    if (duty !== 4'd7 || busy !== 1'b1 || duty_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_ramp_pre got duty=%0d busy=%b valid=%b exp 7 1 1", duty, busy, duty_valid);
    end
`else
    if (duty !== 4'd15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_ramp_pre got duty=%0d busy=%b exp 15 0", duty, busy);
    end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({duty, duty_valid, busy, period_start} !== 7'd0) begin
      errors++;
      $display("FAIL mid_ramp_async got duty=%0d valid=%b busy=%b ps=%b exp 0",
               duty, duty_valid, busy, period_start);
    end
    checks++;
    if (dut.target !== 4'd0) begin
      errors++;
      $display("FAIL mid_ramp_target got %0d exp 0", dut.target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
`ifdef PWM_DUTY_RAMP_EN
      exp_d = (k >= 32) ? 4'd1 : 4'd0;
`else
      exp_d = (k >= 16) ? 4'd15 : 4'd0;
`endif
      checks++;
      if (duty !== exp_d) begin
        errors++;
        $display("FAIL mid_ramp_restart k=%0d got %0d exp %0d", k, duty, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_period_start();
    test_debounce_glitch();
    test_ramp_up();
`ifdef PWM_DUTY_RAMP_EN
    test_retarget();
`else
    test_step_jump();
`endif
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
